// File: rtl/sys_defs.sv
// sys_defs: shared register-file index type and zero-register constant
package sys_defs;
  localparam int DEF_IDX_W = 5;
  localparam int ZERO_REG = 0;
  typedef logic [DEF_IDX_W-1:0] regidx_t;
endpackage

// File: rtl/regfile_mp_wsel.sv
// regfile_mp_wsel: finds the highest-numbered enabled write port targeting idx
module regfile_mp_wsel #(
  parameter int NUM_WR = 1,
  parameter int IDX_W = 5,
  localparam int PW = NUM_WR > 1 ? $clog2(NUM_WR) : 1
) (
  input  logic [IDX_W-1:0]             idx,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0] wr_idx,
  output logic                         hit,
  output logic [PW-1:0]                sel
);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en[p] && wr_idx[p] == idx) begin
        hit = 1'b1;
        sel = PW'(p);
      end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and busy-bit scoreboard
module regfile_mp
  import sys_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int IDX_W = $clog2(NUM_REGS),
  localparam int PW = NUM_WR > 1 ? $clog2(NUM_WR) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD-1:0][IDX_W-1:0]      rd_idx,
  output logic [NUM_RD-1:0][DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]                 rd_busy,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0]      wr_idx,
  input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data,
  input  logic                              alloc_en,
  input  logic [IDX_W-1:0]                  alloc_idx,
  input  logic                              flush,
  output logic [IDX_W:0]                    busy_cnt
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0] wr_hit, busy, busy_nxt;
  logic [IDX_W:0] cnt_nxt;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] q;
    logic [PW-1:0] sel;
    regfile_mp_wsel #(.NUM_WR(NUM_WR), .IDX_W(IDX_W)) u_wsel (
      .idx(IDX_W'(i)), .wr_en(wr_en), .wr_idx(wr_idx), .hit(wr_hit[i]), .sel(sel)
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (wr_hit[i] && !(ZERO_REG_EN && i == ZERO_REG)) q <= wr_data[sel];
    assign regs[i] = q;
  end
  // alloc overrides writeback (younger instruction); flush overrides both
  always_comb begin
    busy_nxt = busy;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit[i]) busy_nxt[i] = 1'b0;
      if (alloc_en && alloc_idx == IDX_W'(i)) busy_nxt[i] = 1'b1;
      if (flush || (ZERO_REG_EN && i == ZERO_REG)) busy_nxt[i] = 1'b0;
      cnt_nxt = cnt_nxt + (IDX_W+1)'(busy_nxt[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic hit, zero, byp, same_alloc;
    logic [PW-1:0] sel;
    regfile_mp_wsel #(.NUM_WR(NUM_WR), .IDX_W(IDX_W)) u_wsel (
      .idx(rd_idx[r]), .wr_en(wr_en), .wr_idx(wr_idx), .hit(hit), .sel(sel)
    );
    assign zero = ZERO_REG_EN && rd_idx[r] == IDX_W'(ZERO_REG);
    assign byp = BYPASS && rst_n && hit;
    assign same_alloc = alloc_en && alloc_idx == rd_idx[r];
    assign rd_data[r] = zero ? '0 : byp ? wr_data[sel] : regs[rd_idx[r]];
    assign rd_busy[r] = zero ? 1'b0 : (byp && !same_alloc) ? 1'b0 : busy[rd_idx[r]];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp with and without bypass
module tb_regfile_mp;
  import sys_defs::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4:0] rd_idx;
  logic [1:0][31:0] rd_data_a, rd_data_b;
  logic [1:0] rd_busy_a, rd_busy_b;
  logic [1:0] wr_en;
  logic [1:0][4:0] wr_idx;
  logic [1:0][31:0] wr_data;
  logic alloc_en, flush;
  regidx_t alloc_idx;
  logic [5:0] busy_cnt_a, busy_cnt_b;
  typedef struct {int k; logic [31:0] v; string tag;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  regfile_mp #(.NUM_WR(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_idx(alloc_idx), .flush(flush), .busy_cnt(busy_cnt_a)
  );
  regfile_mp #(.NUM_WR(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_idx(alloc_idx), .flush(flush), .busy_cnt(busy_cnt_b)
  );
  // k: 0/1/2 = data/busy/cnt of bypass DUT, 3/4/5 = same for non-bypass DUT
  function automatic logic [31:0] obs(input int k);
    case (k)
      0: return rd_data_a[0];
      1: return {31'd0, rd_busy_a[0]};
      2: return {26'd0, busy_cnt_a};
      3: return rd_data_b[0];
      4: return {31'd0, rd_busy_b[0]};
      default: return {26'd0, busy_cnt_b};
    endcase
  endfunction
  task automatic push(input int k, input logic [31:0] v, input string tag);
    exp_t e;
    e.k = k;
    e.v = v;
    e.tag = tag;
    q.push_back(e);
  endtask
  task automatic both(input int k, input logic [31:0] v, input string tag);
    push(k, v, {tag, "_byp"});
    push(k + 3, v, {tag, "_nobyp"});
  endtask
  task automatic check();
    exp_t e;
    logic [31:0] got;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      got = obs(e.k);
      vectors++;
      assert (got === e.v) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.v);
      end
    end
  endtask
  task automatic idle();
    wr_en = '0;
    wr_idx = '0;
    wr_data = '0;
    alloc_en = 1'b0;
    alloc_idx = '0;
    flush = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    rst_n = 1'b0;
    rd_idx = '0;
    idle();
    both(0, 32'h0, "rst_data");
    both(2, 32'h0, "rst_cnt");
    check();
    #6 rst_n = 1'b1;
    tick();
    wr_en = 2'b01; wr_idx[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    alloc_en = 1'b1; alloc_idx = 5'd5;
    tick();
    rd_idx[0] = 5'd5;
    both(0, 32'hDEADBEEF, "r5_written");
    both(1, 32'h1, "r5_busy");
    both(2, 32'h1, "r5_cnt");
    check();
    rst_n = 1'b0;
    both(0, 32'h0, "async_rst_data");
    both(1, 32'h0, "async_rst_busy");
    both(2, 32'h0, "async_rst_cnt");
    check();
    rst_n = 1'b1;
    tick();
    wr_en = 2'b11; wr_idx[0] = 5'd3; wr_idx[1] = 5'd3;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; rd_idx[0] = 5'd3;
    push(0, 32'h22, "ww_bypass");
    push(3, 32'h0, "ww_nobyp_old");
    check();
    tick();
    both(0, 32'h22, "ww_readback");
    check();
    alloc_en = 1'b1; alloc_idx = 5'd7;
    tick();
    rd_idx[0] = 5'd7;
    both(1, 32'h1, "alloc_r7_busy");
    both(2, 32'h1, "alloc_r7_cnt");
    check();
    wr_en = 2'b01; wr_idx[0] = 5'd7; wr_data[0] = 32'h55;
    push(0, 32'h55, "wb_r7_byp_data");
    push(1, 32'h0, "wb_r7_byp_busy");
    push(3, 32'h0, "wb_r7_nobyp_data");
    push(4, 32'h1, "wb_r7_nobyp_busy");
    check();
    tick();
    both(0, 32'h55, "r7_data");
    both(1, 32'h0, "r7_busy");
    both(2, 32'h0, "r7_cnt");
    check();
    alloc_en = 1'b1; alloc_idx = 5'd9;
    tick();
    alloc_en = 1'b1; alloc_idx = 5'd9;
    wr_en = 2'b10; wr_idx[1] = 5'd9; wr_data[1] = 32'hAA; rd_idx[0] = 5'd9;
    push(4, 32'h1, "coll_pre_busy");
    both(2, 32'h1, "coll_pre_cnt");
    check();
    tick();
    both(0, 32'hAA, "coll_data");
    both(1, 32'h1, "coll_busy");
    both(2, 32'h1, "coll_cnt");
    check();
    foreach (rd_idx[i]) rd_idx[i] = 5'd0;
    alloc_en = 1'b1; alloc_idx = 5'd1;
    tick();
    alloc_en = 1'b1; alloc_idx = 5'd2;
    tick();
    alloc_en = 1'b1; alloc_idx = 5'd4;
    tick();
    rd_idx[0] = 5'd4;
    both(1, 32'h1, "pre_flush_busy");
    both(2, 32'h4, "pre_flush_cnt");
    check();
    flush = 1'b1; alloc_en = 1'b1; alloc_idx = 5'd6;
    tick();
    rd_idx[0] = 5'd6;
    both(1, 32'h0, "flush_r6_busy");
    both(2, 32'h0, "flush_cnt");
    check();
    rd_idx[0] = 5'd9;
    both(1, 32'h0, "flush_r9_busy");
    check();
    alloc_en = 1'b1; alloc_idx = 5'd1;
    tick();
    wr_en = 2'b01; wr_idx[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_idx = 5'd0; rd_idx[0] = 5'd0;
    both(0, 32'h0, "r0_same_data");
    both(1, 32'h0, "r0_same_busy");
    check();
    tick();
    both(0, 32'h0, "r0_data");
    both(1, 32'h0, "r0_busy");
    both(2, 32'h1, "r0_cnt");
    check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
